// File: rtl/eth_pt_pkg.sv
// eth_pt_pkg: shared Avalon-ST widths, buffer word layout and write-FSM states
package eth_pt_pkg;
   localparam int AST_DATA_W = 32;
   localparam int AST_EMPTY_W = 2;
   localparam int AST_ERR_W = 6;
   typedef struct packed {
      logic [AST_DATA_W-1:0] data;
      logic sop;
      logic eop;
      logic [AST_EMPTY_W-1:0] empty;
   } ast_word_t;
   localparam int WORD_W = $bits(ast_word_t);
   typedef enum logic [1:0] {WR_IDLE, WR_WRITE, WR_DROP} wr_state_t;
endpackage

// File: rtl/eth_pt_sdp_ram.sv
// eth_pt_sdp_ram: simple dual-port RAM, one write port and one registered read port
module eth_pt_sdp_ram #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 36
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wa,
   input  logic [DATA_W-1:0] wd,
   input  logic              re,
   input  logic [ADDR_W-1:0] ra,
   output logic [DATA_W-1:0] rd
);
   logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
   always_ff @(posedge clk) begin
      if (we) mem[wa] <= wd;
      if (re) rd <= mem[ra];
   end
endmodule

// File: rtl/eth_pt_store_fwd.sv
// eth_pt_store_fwd: store-and-forward Avalon-ST buffer forwarding only complete, error-free packets
module eth_pt_store_fwd
   import eth_pt_pkg::*;
#(
   parameter int ADDR_W = 9,
   parameter int CNT_W = 16
) (
   input  logic                   clk_clk,
   input  logic                   reset_reset,
   input  logic [AST_DATA_W-1:0]  rx_data,
   input  logic                   rx_startofpacket,
   input  logic                   rx_endofpacket,
   input  logic [AST_EMPTY_W-1:0] rx_empty,
   input  logic [AST_ERR_W-1:0]   rx_error,
   input  logic                   rx_valid,
   output logic                   rx_ready,
   output logic [AST_DATA_W-1:0]  tx_data,
   output logic                   tx_startofpacket,
   output logic                   tx_endofpacket,
   output logic [AST_EMPTY_W-1:0] tx_empty,
   output logic                   tx_error,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic [CNT_W-1:0]       cnt_fwd,
   output logic [CNT_W-1:0]       cnt_drop_err,
   output logic [CNT_W-1:0]       cnt_drop_ovf
);
   localparam int PW = ADDR_W + 1;
   localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   wr_state_t state, state_nx;
   logic [PW-1:0] wr_ptr, wr_commit, rd_ptr, pkt_cnt, base;
   logic rx_beat, accept, full, we, commit, rollback, drop_err, drop_ovf;
   logic rd_en, rd_vld, tx_beat, tx_last;
   ast_word_t wr_word, rd_word, tx_word;

   assign rx_ready = !reset_reset;
   assign rx_beat = rx_valid && rx_ready;
   assign accept = rx_beat && (state == WR_WRITE || (state == WR_IDLE && rx_startofpacket));
   // a SOP always (re)starts the packet at the committed end, discarding any unterminated one
   assign base = (state == WR_WRITE && !rx_startofpacket) ? wr_ptr : wr_commit;
   assign full = (base - rd_ptr) == DEPTH;
   assign wr_word = '{data: rx_data, sop: rx_startofpacket, eop: rx_endofpacket,
                      empty: rx_endofpacket ? rx_empty : '0};

   always_ff @(posedge clk_clk) begin
      if (reset_reset) state <= WR_IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (accept) state_nx = rx_endofpacket ? WR_IDLE : full ? WR_DROP : WR_WRITE;
      else if (rx_beat && state == WR_DROP && rx_endofpacket) state_nx = WR_IDLE;
   end

   always_comb begin
      we = accept && !full;
      commit = we && rx_endofpacket && rx_error == '0;
      drop_err = we && rx_endofpacket && rx_error != '0;
      drop_ovf = rx_beat && rx_endofpacket && ((accept && full) || state == WR_DROP);
      rollback = drop_err || (accept && full);
   end

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         wr_ptr <= '0;
         wr_commit <= '0;
      end else begin
         if (rollback) wr_ptr <= wr_commit;
         else if (we) wr_ptr <= base + PW'(1);
         if (commit) wr_commit <= base + PW'(1);
      end
   end

   // the RAM read register doubles as the output stage; it is only refilled when empty or consumed
   assign tx_beat = tx_valid && tx_ready;
   assign tx_last = tx_beat && tx_endofpacket;
   assign rd_en = pkt_cnt != '0 && rd_ptr != wr_commit && (!rd_vld || tx_ready);

   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         rd_ptr <= '0;
         rd_vld <= 1'b0;
         pkt_cnt <= '0;
         cnt_fwd <= '0;
         cnt_drop_err <= '0;
         cnt_drop_ovf <= '0;
      end else begin
         rd_ptr <= rd_ptr + PW'(rd_en);
         rd_vld <= rd_en || (rd_vld && !tx_ready);
         pkt_cnt <= pkt_cnt + PW'(commit) - PW'(tx_last);
         cnt_fwd <= cnt_fwd + CNT_W'(tx_last && !(&cnt_fwd));
         cnt_drop_err <= cnt_drop_err + CNT_W'(drop_err && !(&cnt_drop_err));
         cnt_drop_ovf <= cnt_drop_ovf + CNT_W'(drop_ovf && !(&cnt_drop_ovf));
      end
   end

   eth_pt_sdp_ram #(.ADDR_W(ADDR_W), .DATA_W(WORD_W)) u_ram (
      .clk(clk_clk),
      .we(we),
      .wa(base[ADDR_W-1:0]),
      .wd(wr_word),
      .re(rd_en),
      .ra(rd_ptr[ADDR_W-1:0]),
      .rd(rd_word)
   );

   assign tx_word = rd_vld ? rd_word : '0;
   assign tx_valid = rd_vld;
   assign tx_data = tx_word.data;
   assign tx_startofpacket = tx_word.sop;
   assign tx_endofpacket = tx_word.eop;
   assign tx_empty = tx_word.empty;
   assign tx_error = 1'b0;
endmodule
